// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path constants, queue entry layout and fetch state encoding.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam int unsigned ENTRY_W      = 65;

    typedef struct packed {
        logic        adel;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FS_RUN  = 2'd0,
        FS_ADEL = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head word is read straight from storage.
module fetch_fifo #(
    parameter int unsigned W        = 65,
    parameter int unsigned DEPTH    = 4,
    parameter logic [W-1:0] RST_WORD = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop & (cnt != '0);
    assign do_push = push & ((cnt != (AW+1)'(DEPTH)) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= RST_WORD;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign valid = (cnt != '0);
    assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, credit-limited imem requests, instruction queue.
// FETCH_ALIGN_CHECK_EN: misaligned redirects yield one address-error entry instead of a fetch.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        if_adel,
    input  logic        if_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    // Squash counter has headroom for several stacked redirects before old responses return.
    localparam int unsigned DW = CW + 3;
    localparam int unsigned SW = CW + 1;
    localparam fetch_entry_t RST_ENTRY = '{adel: 1'b0, pc: RESET_PC, instr: NOP_INSTR};

    fetch_state_e  state, state_n;
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic [31:0]   resp_pc, resp_pc_n;
    logic [CW-1:0] cnt_out, cnt_out_n;
    logic [DW-1:0] drop_cnt, drop_n;
    logic          req_q, req_n;
    logic [CW-1:0] q_cnt, q_cnt_n;

    logic          gnt;
    logic          resp_drop;
    logic          resp_live;
    logic          pop;
    logic          push;
    fetch_entry_t  push_data;
    fetch_entry_t  head;
    logic          head_valid;
    logic [31:0]   tgt_pc;
    logic          tgt_misal;

`ifdef FETCH_ALIGN_CHECK_EN
    assign tgt_pc    = redirect_pc;
    assign tgt_misal = |redirect_pc[1:0];
    assign if_adel   = head.adel;
`else
    logic unused_bits;
    assign tgt_pc      = {redirect_pc[31:2], 2'b00};
    assign tgt_misal   = 1'b0;
    assign if_adel     = 1'b0;
    assign unused_bits = ^{redirect_pc[1:0], head.adel};
`endif

    assign gnt       = imem_req & imem_gnt;
    assign resp_drop = imem_rvalid & (drop_cnt != '0);
    assign resp_live = imem_rvalid & (drop_cnt == '0);
    assign pop       = head_valid & if_ready;

    // Next-state: redirect overrides everything; otherwise grants, responses and the adel push.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        resp_pc_n  = resp_pc;
        cnt_out_n  = cnt_out;
        drop_n     = drop_cnt;
        push       = 1'b0;
        push_data  = '{adel: 1'b0, pc: resp_pc, instr: imem_rdata};

        if (redirect_valid) begin
            fetch_pc_n = tgt_pc;
            resp_pc_n  = tgt_pc;
            cnt_out_n  = '0;
            drop_n     = drop_cnt + DW'(cnt_out) + DW'(gnt) - DW'(imem_rvalid);
            state_n    = tgt_misal ? FS_ADEL : FS_RUN;
        end else begin
            if (gnt) fetch_pc_n = fetch_pc + PC_INC;
            cnt_out_n = cnt_out + CW'(gnt) - CW'(resp_live);
            if (resp_drop) drop_n = drop_cnt - DW'(1);
            if (resp_live) begin
                push      = 1'b1;
                resp_pc_n = resp_pc + PC_INC;
            end
            if (state == FS_ADEL) begin
                push      = 1'b1;
                push_data = '{adel: 1'b1, pc: fetch_pc, instr: NOP_INSTR};
                state_n   = FS_HALT;
            end
        end

        q_cnt_n = redirect_valid ? '0 : q_cnt + CW'(push) - CW'(pop);
        req_n   = (state_n == FS_RUN) &&
                  ((SW'(cnt_out_n) + SW'(q_cnt_n)) < SW'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FS_RUN;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            cnt_out  <= '0;
            drop_cnt <= '0;
            req_q    <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            resp_pc  <= resp_pc_n;
            cnt_out  <= cnt_out_n;
            drop_cnt <= drop_n;
            req_q    <= req_n;
        end
    end

    fetch_fifo #(
        .W        (ENTRY_W),
        .DEPTH    (DEPTH),
        .RST_WORD (RST_ENTRY)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .flush (redirect_valid),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .valid (head_valid),
        .count (q_cnt)
    );

    assign imem_req  = req_q;
    assign imem_addr = fetch_pc;
    assign if_valid  = head_valid;
    assign if_instr  = head.instr;
    assign if_pc     = head.pc;
    assign if_pc4    = head.pc + PC_INC;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model plus stream-level expected-PC model.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_adel;
    logic        if_ready;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .if_adel        (if_adel),
        .if_ready       (if_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // memory model: granted addresses in order with their earliest response cycle
    logic [31:0] mq_addr[$];
    int          mq_rdy[$];
    int gnt_pct = 100, rv_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1;

    // stream model: 0 normal, 1 address-error entry expected, 2 halted after it
    logic [31:0] exp_pc, exp_fetch, redir_tgt, last_gnt_addr;
    int  mode;
    bit  redir_prev, redir_prev_adel;
    bit  last_gnt, last_rv, seen_wrap;
    int  n_pops, n_gnts;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic bit misal_traps(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
        return (t[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: called at a negedge, drives inputs, checks, then advances past the next posedge.
    task automatic cycle(input bit redir, input logic [31:0] tgt);
        bit g, r, p;
        logic [31:0] ga;
        g = (imem_req === 1'b1) && ($urandom_range(99) < gnt_pct);
        r = (mq_addr.size() > 0) && (mq_rdy[0] <= cyc) && ($urandom_range(99) < rv_pct);
        ga = imem_addr;
        imem_gnt    = g;
        imem_rvalid = r;
        if (r) imem_rdata = mem_word(mq_addr[0]);
        else   imem_rdata = $urandom;
        if_ready       = ($urandom_range(99) < ready_pct);
        redirect_valid = redir;
        redirect_pc    = tgt;

        if (redir_prev) begin
            checks++;
            if (if_valid !== 1'b0) begin
                errors++;
                $display("FAIL redir_flush: if_valid=%b required 0 (cyc %0d)", if_valid, cyc);
            end
            checks++;
            if (redir_prev_adel) begin
                if (imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_adel_noreq: imem_req=%b required 0", imem_req);
                end
            end else if (imem_req !== 1'b1 || imem_addr !== redir_tgt) begin
                errors++;
                $display("FAIL redir_refetch: req=%b addr=%h required req=1 addr=%h",
                         imem_req, imem_addr, redir_tgt);
            end
        end
        if (mode != 0) begin
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL halt_req: imem_req=%b required 0 (cyc %0d)", imem_req, cyc);
            end
        end

        p = (if_valid === 1'b1) && if_ready;
        if (p) begin
            checks++;
            if (mode == 1) begin
                if (if_adel !== 1'b1 || if_instr !== 32'h0 || if_pc !== redir_tgt) begin
                    errors++;
                    $display("FAIL adel_entry: adel=%b instr=%h pc=%h required 1/00000000/%h",
                             if_adel, if_instr, if_pc, redir_tgt);
                end
            end else if (mode == 2) begin
                errors++;
                $display("FAIL after_adel: got entry pc=%h required no entry", if_pc);
            end else if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc) ||
                         if_pc4 !== exp_pc + 32'd4 || if_adel !== 1'b0) begin
                errors++;
                $display("FAIL pop: pc=%h instr=%h pc4=%h adel=%b required pc=%h instr=%h pc4=%h adel=0",
                         if_pc, if_instr, if_pc4, if_adel, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
            end
        end
        if (g) begin
            checks++;
            if (ga !== exp_fetch) begin
                errors++;
                $display("FAIL fetch_addr: imem_addr=%h required %h (cyc %0d)", ga, exp_fetch, cyc);
            end
            if (ga == 32'h0 && last_gnt_addr == 32'hFFFF_FFFC) seen_wrap = 1'b1;
            last_gnt_addr = ga;
        end

        @(posedge clk);
        if (g) begin
            mq_addr.push_back(ga);
            mq_rdy.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            exp_fetch = exp_fetch + 32'd4;
            n_gnts++;
        end
        if (r) begin
            void'(mq_addr.pop_front());
            void'(mq_rdy.pop_front());
        end
        if (p) begin
            n_pops++;
            if (mode == 1) mode = 2;
            else if (mode == 0) exp_pc = exp_pc + 32'd4;
        end
        redir_prev = redir;
        if (redir) begin
            redir_prev_adel = misal_traps(tgt);
            if (redir_prev_adel) begin
                mode      = 1;
                redir_tgt = tgt;
            end else begin
                mode      = 0;
                redir_tgt = {tgt[31:2], 2'b00};
                exp_pc    = redir_tgt;
                exp_fetch = redir_tgt;
            end
        end
        last_gnt = g;
        last_rv  = r;
        cyc++;
        @(negedge clk);
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
    endtask

    task automatic set_mem(input int gp, input int rp, input int rdy, input int lmin, input int lmax);
        gnt_pct = gp; rv_pct = rp; ready_pct = rdy; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: %b required 0", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr: %h required %h", imem_addr, RESET_PC); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: %b required 0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: %h required 0", if_instr); end
        checks++; if (if_pc !== RESET_PC) begin errors++; $display("FAIL rst_pc: %h required %h", if_pc, RESET_PC); end
        checks++; if (if_pc4 !== RESET_PC + 32'd4) begin errors++; $display("FAIL rst_pc4: %h required %h", if_pc4, RESET_PC + 32'd4); end
        checks++; if (if_adel !== 1'b0) begin errors++; $display("FAIL rst_adel: %b required 0", if_adel); end
        mq_addr.delete(); mq_rdy.delete();
        exp_pc = RESET_PC; exp_fetch = RESET_PC; mode = 0;
        redir_prev = 1'b0; redir_prev_adel = 1'b0; last_gnt_addr = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h required 1/%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int p0;
        set_mem(100, 100, 100, 1, 1);
        run(5);
        p0 = n_pops;
        run(20);
        checks++;
        if (n_pops - p0 != 20) begin
            errors++;
            $display("FAIL throughput: %0d pops in 20 cycles required 20", n_pops - p0);
        end
    endtask

    task automatic test_stall();
        int g0, p0;
        test_reset();
        set_mem(100, 100, 0, 1, 1);
        g0 = n_gnts;
        run(10);
        checks++;
        if (n_gnts - g0 != int'(DEPTH)) begin
            errors++;
            $display("FAIL stall_grants: %0d grants required %0d", n_gnts - g0, DEPTH);
        end
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_state: req=%b valid=%b required 0/1", imem_req, if_valid);
        end
        ready_pct = 100;
        p0 = n_pops;
        run(12);
        checks++;
        if (n_pops - p0 < int'(DEPTH)) begin
            errors++;
            $display("FAIL stall_release: %0d pops required >= %0d", n_pops - p0, DEPTH);
        end
    endtask

    task automatic test_redirect_outstanding();
        bit found = 1'b0;
        int p0;
        test_reset();
        set_mem(100, 100, 0, 2, 2);
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq_addr.size() == 2 && if_valid === 1'b1) found = 1'b1;
            else cycle(1'b0, 32'h0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redir_setup: outstanding=%0d valid=%b required 2/1", mq_addr.size(), if_valid);
        end
        cycle(1'b1, 32'h0000_3100);
        set_mem(100, 100, 100, 1, 2);
        p0 = n_pops;
        run(15);
        checks++;
        if (n_pops - p0 < 5) begin
            errors++;
            $display("FAIL redir_progress: %0d pops required >= 5", n_pops - p0);
        end
    endtask

    task automatic test_redirect_coincident();
        bit found = 1'b0;
        int p0;
        set_mem(100, 100, 100, 1, 1);
        run(4);
        for (int i = 0; i < 10 && !found; i++) begin
            if (imem_req === 1'b1 && mq_addr.size() > 0 && mq_rdy[0] <= cyc) found = 1'b1;
            else cycle(1'b0, 32'h0);
        end
        cycle(1'b1, 32'h0000_3200);
        checks++;
        if (!(last_gnt && last_rv)) begin
            errors++;
            $display("FAIL coincident_setup: gnt=%b rvalid=%b required 1/1", last_gnt, last_rv);
        end
        p0 = n_pops;
        run(12);
        checks++;
        if (n_pops - p0 < 8) begin
            errors++;
            $display("FAIL coincident_progress: %0d pops required >= 8", n_pops - p0);
        end
    endtask

    task automatic test_wrap();
        set_mem(100, 100, 100, 1, 1);
        seen_wrap = 1'b0;
        cycle(1'b1, 32'hFFFF_FFF8);
        run(12);
        checks++;
        if (!seen_wrap) begin
            errors++;
            $display("FAIL wrap: fetch of 00000000 after fffffffc seen=%b required 1", seen_wrap);
        end
    endtask

    task automatic test_misaligned();
        int p0;
        set_mem(100, 100, 100, 1, 1);
        cycle(1'b1, 32'h0000_3102);
`ifdef FETCH_ALIGN_CHECK_EN
        run(8);
        checks++;
        if (mode != 2) begin
            errors++;
            $display("FAIL adel_delivered: model state %0d required 2", mode);
        end
        cycle(1'b1, 32'h0000_3000);
`endif
        p0 = n_pops;
        run(10);
        checks++;
        if (n_pops - p0 < 5) begin
            errors++;
            $display("FAIL misaligned_progress: %0d pops required >= 5", n_pops - p0);
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        int p0;
        set_mem(70, 80, 70, 1, 3);
        p0 = n_pops;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 3) begin
                t = $urandom & 32'h0000_FFFC;
                if ($urandom_range(9) == 0) t[1:0] = 2'($urandom_range(3, 1));
                cycle(1'b1, t);
            end else begin
                cycle(1'b0, 32'h0);
            end
        end
        checks++;
        if (n_pops - p0 < 200) begin
            errors++;
            $display("FAIL random_progress: %0d pops required >= 200", n_pops - p0);
        end
        test_reset();
        set_mem(100, 100, 100, 1, 1);
        run(10);
    endtask

    initial begin
        reset = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        n_pops = 0; n_gnts = 0; mode = 0; seen_wrap = 1'b0;
        redir_prev = 1'b0; redir_prev_adel = 1'b0;
        #3;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_outstanding();
        test_redirect_coincident();
        test_wrap();
        test_misaligned();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
